// File: rtl/can_seq_det.sv
// can_seq_det: serial LEN-bit pattern loader and stream matcher with a
// saturating match counter. Ports: clk, rst_n, load, din, din_valid,
// overlap, clr_cnt, [mask if SEQ_DET_MASK_EN], dout, armed, load_err, match_cnt.
module can_seq_det #(
  parameter int LEN   = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic             clr_cnt,
`ifdef SEQ_DET_MASK_EN
  input  logic [LEN-1:0]   mask,
`endif
  output logic             dout,
  output logic             armed,
  output logic             load_err,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DETECT
  } state_e;

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] FULL = CW'(LEN);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e           state_q, state_d;
  logic [LEN-1:0]   pat_q, pat_d;
  logic [LEN-1:0]   hist_q, hist_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    lcnt_q, lcnt_d;
  logic             dout_q, dout_d;
  logic             armed_q, armed_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [LEN-1:0]   hist_nx;
  logic [LEN-1:0]   care;
  logic [CW-1:0]    fill_inc;
  logic [CW-1:0]    lbase;
  logic             eq;
  logic             hit;

`ifdef SEQ_DET_MASK_EN
  assign care = ~mask;
`else
  assign care = '1;
`endif

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    lcnt_d   = lcnt_q;
    armed_d  = armed_q;
    err_d    = 1'b0;
    hit      = 1'b0;
    hist_nx  = {hist_q[LEN-2:0], din};
    eq       = ((hist_nx ^ pat_q) & care) == '0;
    fill_inc = (fill_q == FULL) ? FULL : fill_q + CW'(1);
    // the load count restarts when LOAD is entered from another state
    lbase    = (state_q == LOAD) ? lcnt_q : '0;

    unique case (1'b1)
      load: begin
        state_d = LOAD;
        hist_d  = '0;
        fill_d  = '0;
        armed_d = 1'b0;
        lcnt_d  = lbase;
        if (din_valid) begin
          pat_d  = {pat_q[LEN-2:0], din};
          lcnt_d = (lbase == FULL) ? FULL : lbase + CW'(1);
        end
      end
      (state_q == LOAD) && !load: begin
        lcnt_d = '0;
        if (lcnt_q == FULL) begin
          state_d = DETECT;
          armed_d = 1'b1;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
          pat_d   = '0;
        end
      end
      (state_q == DETECT) && !load && din_valid: begin
        hist_d = hist_nx;
        fill_d = fill_inc;
        hit    = (fill_inc == FULL) && eq;
        // non-overlapping mode needs LEN fresh bits after a hit
        if (hit && !overlap) fill_d = '0;
      end
      default: ;
    endcase

    cnt_d = cnt_q;
    if (clr_cnt)
      cnt_d = hit ? CNT_W'(1) : '0;
    else if (hit && cnt_q != CMAX)
      cnt_d = cnt_q + CNT_W'(1);

    dout_d = hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      lcnt_q  <= '0;
      dout_q  <= 1'b0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      lcnt_q  <= lcnt_d;
      dout_q  <= dout_d;
      armed_q <= armed_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout      = dout_q;
  assign armed     = armed_q;
  assign load_err  = err_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_can_seq_det.sv
// Bench for can_seq_det: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_can_seq_det;

  localparam int LEN   = 8;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic load, din, din_valid, overlap, clr_cnt;
  logic [LEN-1:0] mask;
  logic dout, armed, load_err;
  logic [CNT_W-1:0] match_cnt;

  int nchk = 0;
  int nerr = 0;

  can_seq_det #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .din       (din),
    .din_valid (din_valid),
    .overlap   (overlap),
    .clr_cnt   (clr_cnt),
`ifdef SEQ_DET_MASK_EN
    .mask      (mask),
`endif
    .dout      (dout),
    .armed     (armed),
    .load_err  (load_err),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  // reference model: 0 idle, 1 loading, 2 detecting
  int m_mode;
  bit m_pat[$];
  bit m_win[$];
  int m_cnt;
  bit m_dout, m_armed, m_err;

  task automatic m_reset();
    m_mode = 0;
    m_pat.delete();
    m_win.delete();
    m_cnt = 0;
    m_dout = 0;
    m_armed = 0;
    m_err = 0;
  endtask

  task automatic m_step(bit l, bit d, bit v, bit o, bit c);
    bit hit;
    logic [LEN-1:0] pv, wv, mk;
    hit = 0;
    m_err = 0;
    mk = 0;
`ifdef SEQ_DET_MASK_EN
    mk = mask;
`endif
    if (l) begin
      if (m_mode != 1) m_pat.delete();
      m_mode = 1;
      m_win.delete();
      m_armed = 0;
      if (v) begin
        m_pat.push_back(d);
        if (m_pat.size() > LEN) void'(m_pat.pop_front());
      end
    end else if (m_mode == 1) begin
      if (m_pat.size() == LEN) begin
        m_mode = 2;
        m_armed = 1;
      end else begin
        m_mode = 0;
        m_err = 1;
        m_pat.delete();
      end
    end else if (m_mode == 2 && v) begin
      m_win.push_back(d);
      if (m_win.size() > LEN) void'(m_win.pop_front());
      if (m_win.size() == LEN) begin
        pv = 0;
        wv = 0;
        for (int i = 0; i < LEN; i++) begin
          pv = {pv[LEN-2:0], m_pat[i]};
          wv = {wv[LEN-2:0], m_win[i]};
        end
        hit = ((pv ^ wv) & ~mk) == 0;
      end
      if (hit && !o) m_win.delete();
    end
    m_dout = hit;
    if (c) m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < CMAX) m_cnt++;
  endtask

  // one clock: drive at negedge, check at the following negedge
  task automatic cyc(bit l, bit d, bit v, bit o, bit c);
    load = l;
    din = d;
    din_valid = v;
    overlap = o;
    clr_cnt = c;
    m_step(l, d, v, o, c);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic load_pat(logic [7:0] p, bit o);
    cyc(1, 0, 0, o, 0);
    for (int i = 7; i >= 0; i--) cyc(1, p[i], 1, o, 0);
    cyc(0, 0, 0, o, 0);
  endtask

  typedef struct {
    logic l, d, v, o, c;
    logic ed, ea, ee;
    logic [1:0] ecnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(logic l, logic d, logic v, logic o, logic c,
                     logic ed, logic ea, logic ee, logic [1:0] ecnt);
    vec_t t;
    t.l = l; t.d = d; t.v = v; t.o = o; t.c = c;
    t.ed = ed; t.ea = ea; t.ee = ee; t.ecnt = ecnt;
    tbl.push_back(t);
  endtask

  initial begin
    logic [7:0] a5, aa, ff, a0, p25;
    logic [9:0] b10;
    int run, k;
    bit l, d, v, o, c;
    a5 = 8'hA5; aa = 8'hAA; ff = 8'hFF; a0 = 8'hA0; p25 = 8'h25;
    mask = '0;
    load = 0; din = 0; din_valid = 0; overlap = 0; clr_cnt = 0;
    rst_n = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("reset", {dout, armed, load_err, match_cnt}, 0);

    // table: full load + match, then short load + dead stream
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 7; i >= 0; i--) add(1, a5[i], 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 7; i >= 0; i--)
      add(0, a5[i], 1, 1, 0, i == 0, 1, 0, (i == 0) ? 2'd1 : 2'd0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 7; i >= 3; i--) add(1, a5[i], 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 7; i >= 0; i--) add(0, a5[i], 1, 1, 0, 0, 0, 0, 1);
    foreach (tbl[i]) begin
      cyc(tbl[i].l, tbl[i].d, tbl[i].v, tbl[i].o, tbl[i].c);
      chk($sformatf("tbl%0d", i), {dout, armed, load_err, match_cnt},
          {tbl[i].ed, tbl[i].ea, tbl[i].ee, tbl[i].ecnt});
    end

    // async reset after 4 of 8 pattern bits; count is 1 here
    cyc(1, 0, 0, 1, 0);
    for (int i = 7; i >= 4; i--) cyc(1, a5[i], 1, 1, 0);
    rst_n = 0;
    #1;
    chk("rst_async", {dout, armed, load_err, match_cnt}, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 7; i >= 0; i--) begin
      cyc(0, a5[i], 1, 1, 0);
      chk("rst_nodout", {dout, armed}, 0);
    end
    load_pat(a5, 1);
    for (int i = 7; i >= 0; i--) cyc(0, a5[i], 1, 1, 0);
    chk("reload", {dout, armed, match_cnt}, {1'b1, 1'b1, 2'd1});

    // overlapping AA: hits on bits 8 and 10
    b10 = 10'b1010101010;
    cyc(0, 0, 0, 1, 1);
    load_pat(aa, 1);
    for (int j = 0; j < 10; j++) begin
      cyc(0, b10[9-j], 1, 1, 0);
      chk($sformatf("ovl_b%0d", j + 1), dout, (j == 7 || j == 9));
    end
    chk("ovl_cnt", match_cnt, 2);

    // non-overlapping AA: single hit
    cyc(0, 0, 0, 0, 1);
    load_pat(aa, 0);
    for (int j = 0; j < 10; j++) begin
      cyc(0, b10[9-j], 1, 0, 0);
      chk($sformatf("novl_b%0d", j + 1), dout, (j == 7));
    end
    chk("novl_cnt", match_cnt, 1);

    // five hits saturate the 2-bit counter, then clear with a hit
    cyc(0, 0, 0, 1, 1);
    load_pat(aa, 1);
    for (int j = 0; j < 16; j++) cyc(0, (j % 2) == 0, 1, 1, 0);
    chk("sat_cnt", match_cnt, 3);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 1);
    chk("clr_hit", {dout, match_cnt}, {1'b1, 2'd1});

    // periodic all-ones pattern gives consecutive pulses
    load_pat(ff, 1);
    for (int j = 0; j < 10; j++) begin
      cyc(0, 1, 1, 1, 0);
      chk($sformatf("b2b_b%0d", j + 1), dout, (j >= 7));
    end

`ifdef SEQ_DET_MASK_EN
    mask = 8'h0F;
    cyc(0, 0, 0, 0, 1);
    load_pat(a5, 0);
    for (int i = 7; i >= 0; i--) cyc(0, a0[i], 1, 0, 0);
    chk("mask_hit", {dout, match_cnt}, {1'b1, 2'd1});
    for (int i = 7; i >= 0; i--) begin
      cyc(0, p25[i], 1, 0, 0);
      chk("mask_miss", dout, 0);
    end
    mask = '0;
`endif

    // randomized run against the model
    rst_n = 0;
    #1;
    m_reset();
    @(negedge clk);
    rst_n = 1;
    run = 0;
    k = 0;
    for (int n = 0; n < 3000; n++) begin
      l = 0;
      if (run > 0) begin
        l = 1;
        run--;
      end else if ($urandom % 60 == 0) begin
        run = $urandom_range(12, 2);
      end
      v = ($urandom % 8) != 0;
      o = $urandom % 2;
      c = ($urandom % 64) == 0;
      if (!l && m_mode == 2 && m_pat.size() == LEN && ($urandom % 4) != 0) begin
        d = m_pat[k % LEN];
        if (v) k++;
      end else begin
        d = $urandom % 2;
      end
      cyc(l, d, v, o, c);
      chk("rand", {dout, armed, load_err, match_cnt},
          {m_dout, m_armed, m_err, 2'(m_cnt)});
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
